// File: rtl/ctrl_wei_pkg.sv
// Shared definitions for the weight scheduler: state encoding, index-width helper
// and default sizing.
package ctrl_wei_pkg;

    localparam int DEF_NUM_PEC        = 48;
    localparam int DEF_PREFETCH_DEPTH = 3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREFETCH = 2'd1,
        ST_WAITGET  = 2'd2,
        ST_WAITVAL  = 2'd3
    } state_t;

    // Never returns 0, so a single-PEC build still gets a 1-bit index.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/ctrl_wei_pick.sv
// Next-enabled-PEC finder: highest enabled index below i_from, else wraps to the
// highest enabled index below i_n_act. o_any is low when nothing below i_n_act is enabled.
module ctrl_wei_pick
    import ctrl_wei_pkg::*;
#(
    parameter int NUM_PEC = DEF_NUM_PEC,
    parameter int IDW     = clog2(NUM_PEC)
) (
    input  logic [IDW:0]       i_from,
    input  logic [IDW:0]       i_n_act,
    input  logic [NUM_PEC-1:0] i_mask,
    output logic [IDW-1:0]     o_idx,
    output logic               o_any
);

    logic [IDW-1:0] w_below;
    logic           w_has_below;
    logic [IDW-1:0] w_top;
    logic           w_has_top;

    // Ascending scan: the last hit is the highest qualifying index.
    always_comb begin
        w_below     = '0;
        w_has_below = 1'b0;
        w_top       = '0;
        w_has_top   = 1'b0;
        for (int i = 0; i < NUM_PEC; i++) begin
            if (i_mask[i]) begin
                if (i < int'(i_from)) begin
                    w_below     = IDW'(i);
                    w_has_below = 1'b1;
                end
                if (i < int'(i_n_act)) begin
                    w_top     = IDW'(i);
                    w_has_top = 1'b1;
                end
            end
        end
        o_idx = w_has_below ? w_below : w_top;
        o_any = w_has_top;
    end

endmodule

// File: rtl/ctrl_wei_sched.sv
// Weight scheduler: prefetches a burst of weight sets, then hands one set to each active
// PEC in descending order. Optional per-PEC mask enabled by defining CTRL_WEI_MASK_EN.
module ctrl_wei_sched
    import ctrl_wei_pkg::*;
#(
    parameter int NUM_PEC        = DEF_NUM_PEC,
    parameter int PREFETCH_DEPTH = DEF_PREFETCH_DEPTH,
    localparam int IDW           = clog2(NUM_PEC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               top_sta,
    input  logic               gbf_flg_val,
    input  logic               gbf_wei_val,
    input  logic [IDW:0]       cfg_num_pec,
`ifdef CTRL_WEI_MASK_EN
    input  logic [NUM_PEC-1:0] cfg_pec_mask,
`endif
    input  logic               dis_rdy_wei,
    input  logic [NUM_PEC-1:0] pec_get_wei,
    input  logic               fnh_frm,
    input  logic               fnh_cfg,
    output logic [NUM_PEC-1:0] pec_rdy_wei,
    output logic               pls_fetch,
    output logic [IDW-1:0]     cur_pec,
    output logic               busy,
    output logic               err_get,
    output logic [1:0]         dbg_state
);

    localparam logic [IDW:0]   NP_W    = (IDW+1)'(NUM_PEC);
    localparam logic [3:0]     PD_W    = 4'(PREFETCH_DEPTH);
    localparam logic [IDW-1:0] TOP_IDX = IDW'(NUM_PEC - 1);

    state_t             r_state;
    logic [3:0]         r_pf_cnt;
    logic [IDW-1:0]     r_cur_pec;
    logic [IDW:0]       r_n_act;
    logic [NUM_PEC-1:0] r_mask;
    logic [NUM_PEC-1:0] r_rdy;
    logic               r_err;

    logic               w_wei_val;
    logic               w_in_idle;
    logic [IDW:0]       w_n_act_in;
    logic [NUM_PEC-1:0] w_mask_in;
    logic [NUM_PEC-1:0] w_pick_mask;
    logic [IDW:0]       w_pick_n_act;
    logic [IDW:0]       w_pick_from;
    logic [IDW-1:0]     w_pick_idx;
    logic               w_pick_any;
    logic [NUM_PEC-1:0] w_cur_onehot;
    logic               w_any_get;
    logic               w_bad_get;

`ifdef CTRL_WEI_MASK_EN
    assign w_mask_in = cfg_pec_mask;
`else
    assign w_mask_in = '1;
`endif

    assign w_wei_val  = gbf_flg_val & gbf_wei_val;
    assign w_in_idle  = (r_state == ST_IDLE);
    assign w_n_act_in = (cfg_num_pec == '0 || cfg_num_pec > NP_W) ? NP_W : cfg_num_pec;

    // In IDLE the picker looks at the incoming config so cur_pec is valid on entry;
    // WAITVAL steps down from cur_pec, everywhere else it restarts from the top.
    assign w_pick_mask  = w_in_idle ? w_mask_in : r_mask;
    assign w_pick_n_act = w_in_idle ? w_n_act_in : r_n_act;
    assign w_pick_from  = (r_state == ST_WAITVAL) ? {1'b0, r_cur_pec} : w_pick_n_act;

    ctrl_wei_pick #(
        .NUM_PEC (NUM_PEC),
        .IDW     (IDW)
    ) u_pick (
        .i_from  (w_pick_from),
        .i_n_act (w_pick_n_act),
        .i_mask  (w_pick_mask),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    assign w_cur_onehot = NUM_PEC'(1) << r_cur_pec;
    assign w_any_get    = |pec_get_wei;
    assign w_bad_get    = w_any_get &&
                          ((r_state != ST_WAITGET) || ((pec_get_wei & ~w_cur_onehot) != '0));

    assign pls_fetch = !rst && w_wei_val &&
                       (((r_state == ST_PREFETCH) && (r_pf_cnt < PD_W)) ||
                        (r_state == ST_WAITVAL));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pf_cnt  <= '0;
            r_cur_pec <= TOP_IDX;
            r_n_act   <= NP_W;
            r_mask    <= '1;
            r_rdy     <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (top_sta && w_pick_any) begin
                        r_state   <= ST_PREFETCH;
                        r_pf_cnt  <= '0;
                        r_n_act   <= w_n_act_in;
                        r_mask    <= w_mask_in;
                        r_cur_pec <= w_pick_idx;
                    end
                end
                ST_PREFETCH: begin
                    if (w_wei_val) begin
                        if (r_pf_cnt < PD_W) r_pf_cnt <= r_pf_cnt + 4'd1;
                        else                 r_state  <= ST_WAITGET;
                    end
                end
                ST_WAITGET: begin
                    if (fnh_cfg) begin
                        r_state <= ST_IDLE;
                    end else if (fnh_frm) begin
                        r_state   <= ST_PREFETCH;
                        r_pf_cnt  <= '0;
                        r_cur_pec <= w_pick_idx;
                    end else if (w_any_get) begin
                        r_state <= ST_WAITVAL;
                    end
                end
                ST_WAITVAL: begin
                    if (w_wei_val) begin
                        r_state   <= ST_WAITGET;
                        r_cur_pec <= w_pick_idx;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // A take or a frame end withdraws the offer, even if it would be re-offered now.
            if (w_any_get || fnh_frm)                       r_rdy <= '0;
            else if (dis_rdy_wei && r_state == ST_WAITGET)  r_rdy <= w_cur_onehot;

            if (w_bad_get) r_err <= 1'b1;
        end
    end

    assign pec_rdy_wei = r_rdy;
    assign cur_pec     = r_cur_pec;
    assign busy        = (r_state != ST_IDLE);
    assign err_get     = r_err;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_ctrl_wei_sched.sv
// Directed bench for ctrl_wei_sched (NUM_PEC=8, PREFETCH_DEPTH=3); mask tests run
// only when CTRL_WEI_MASK_EN is defined.
module tb_ctrl_wei_sched;

    localparam int NP = 8;

    logic       clk;
    logic       rst;
    logic       top_sta;
    logic       gbf_flg_val;
    logic       gbf_wei_val;
    logic [3:0] cfg_num_pec;
`ifdef CTRL_WEI_MASK_EN
    logic [NP-1:0] cfg_pec_mask;
`endif
    logic          dis_rdy_wei;
    logic [NP-1:0] pec_get_wei;
    logic          fnh_frm;
    logic          fnh_cfg;
    logic [NP-1:0] pec_rdy_wei;
    logic          pls_fetch;
    logic [2:0]    cur_pec;
    logic          busy;
    logic          err_get;
    logic [1:0]    dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [NP-1:0] exp_q[$];

    ctrl_wei_sched #(
        .NUM_PEC        (NP),
        .PREFETCH_DEPTH (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .top_sta      (top_sta),
        .gbf_flg_val  (gbf_flg_val),
        .gbf_wei_val  (gbf_wei_val),
        .cfg_num_pec  (cfg_num_pec),
`ifdef CTRL_WEI_MASK_EN
        .cfg_pec_mask (cfg_pec_mask),
`endif
        .dis_rdy_wei  (dis_rdy_wei),
        .pec_get_wei  (pec_get_wei),
        .fnh_frm      (fnh_frm),
        .fnh_cfg      (fnh_cfg),
        .pec_rdy_wei  (pec_rdy_wei),
        .pls_fetch    (pls_fetch),
        .cur_pec      (cur_pec),
        .busy         (busy),
        .err_get      (err_get),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled and inputs driven 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [1:0] st, input string tag);
        int n;
        n = 0;
        while (dbg_state !== st && n < 20) begin
            tick();
            n++;
        end
        check(tag, 32'(dbg_state), 32'(st));
    endtask

    // Entered on the first PREFETCH cycle with weights valid every cycle.
    task automatic prefetch_burst(input string tag);
        logic [5:0] pat;
        int first_wg;
        pat = '0;
        first_wg = 99;
        for (int i = 0; i < 6; i++) begin
            pat[i] = pls_fetch;
            if (dbg_state == 2'd2 && first_wg == 99) first_wg = i;
            tick();
        end
        check({tag, "_pulses"}, 32'(pat), 32'h07);
        check({tag, "_waitget_cyc"}, 32'(first_wg), 32'd4);
    endtask

    // Entered in WAITGET with dis_rdy_wei high; serves n PECs, expected rdy from exp_q.
    task automatic serve(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            logic [NP-1:0] e;
            e = exp_q.pop_front();
            tick();
            check({tag, "_rdy"}, 32'(pec_rdy_wei), 32'(e));
            pec_get_wei = e;
            gbf_flg_val = 1'b0;
            #1 check({tag, "_nopls_at_get"}, 32'(pls_fetch), 32'd0);
            tick();
            pec_get_wei = '0;
            check({tag, "_rdy_cleared"}, 32'(pec_rdy_wei), 32'd0);
            check({tag, "_waitval"}, 32'(dbg_state), 32'd3);
            #1 check({tag, "_hold_nopls"}, 32'(pls_fetch), 32'd0);
            gbf_flg_val = 1'b1;
            #1 check({tag, "_pls_on_val"}, 32'(pls_fetch), 32'd1);
            tick();
        end
    endtask

    initial begin
        rst         = 1'b1;
        top_sta     = 1'b0;
        gbf_flg_val = 1'b0;
        gbf_wei_val = 1'b0;
        cfg_num_pec = 4'd0;
`ifdef CTRL_WEI_MASK_EN
        cfg_pec_mask = 8'hFF;
`endif
        dis_rdy_wei = 1'b0;
        pec_get_wei = '0;
        fnh_frm     = 1'b0;
        fnh_cfg     = 1'b0;
        repeat (2) tick();

        check("rst_busy",  32'(busy),        32'd0);
        check("rst_state", 32'(dbg_state),   32'd0);
        check("rst_cur",   32'(cur_pec),     32'd7);
        check("rst_rdy",   32'(pec_rdy_wei), 32'd0);
        check("rst_err",   32'(err_get),     32'd0);
        check("rst_pls",   32'(pls_fetch),   32'd0);
        rst = 1'b0;
        tick();

        // cfg_num_pec=0 clamps to 8 PECs; steady weights give a 3-pulse burst
        gbf_flg_val = 1'b1;
        gbf_wei_val = 1'b1;
        top_sta     = 1'b1;
        #1 check("idle_nopls", 32'(pls_fetch), 32'd0);
        tick();
        top_sta = 1'b0;
        check("clamp_cur", 32'(cur_pec), 32'd7);
        prefetch_burst("a_pf");
        fnh_cfg = 1'b1;
        tick();
        fnh_cfg = 1'b0;
        check("a_idle", 32'(busy), 32'd0);

        // four PECs served 3,2,1,0 then wrap to 3
        cfg_num_pec = 4'd4;
        top_sta     = 1'b1;
        tick();
        top_sta = 1'b0;
        check("b_cur_start", 32'(cur_pec), 32'd3);
        wait_state(2'd2, "b_waitget");
        dis_rdy_wei = 1'b1;
        exp_q.push_back(8'h08);
        exp_q.push_back(8'h04);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h08);
        serve(5, "b");
        check("b_no_err", 32'(err_get), 32'd0);

        // frame end while bit 2 is offered
        tick();
        check("c_rdy2", 32'(pec_rdy_wei), 32'h04);
        fnh_frm = 1'b1;
        tick();
        fnh_frm     = 1'b0;
        dis_rdy_wei = 1'b0;
        check("c_rdy_cleared", 32'(pec_rdy_wei), 32'd0);
        check("c_prefetch",    32'(dbg_state),   32'd1);
        check("c_cur_reload",  32'(cur_pec),     32'd3);
        prefetch_burst("c_pf");

        // wrong-PEC take, coinciding with a distributor offer
        fnh_cfg = 1'b1;
        tick();
        fnh_cfg     = 1'b0;
        cfg_num_pec = 4'd8;
        top_sta     = 1'b1;
        tick();
        top_sta = 1'b0;
        wait_state(2'd2, "d_waitget");
        check("d_cur7", 32'(cur_pec), 32'd7);
        dis_rdy_wei = 1'b1;
        pec_get_wei = 8'h20;
        gbf_flg_val = 1'b0;
        tick();
        pec_get_wei = '0;
        dis_rdy_wei = 1'b0;
        check("d_rdy_zero", 32'(pec_rdy_wei), 32'd0);
        check("d_err_set",  32'(err_get),     32'd1);
        check("d_waitval",  32'(dbg_state),   32'd3);
        repeat (2) tick();
        check("d_err_held", 32'(err_get), 32'd1);

        // reset in WAITVAL with weights valid
        gbf_flg_val = 1'b1;
        rst         = 1'b1;
        #1 check("e_rst_nopls", 32'(pls_fetch), 32'd0);
        tick();
        rst = 1'b0;
        check("e_state", 32'(dbg_state),   32'd0);
        check("e_cur",   32'(cur_pec),     32'd7);
        check("e_rdy",   32'(pec_rdy_wei), 32'd0);
        check("e_err",   32'(err_get),     32'd0);
        check("e_busy",  32'(busy),        32'd0);

`ifdef CTRL_WEI_MASK_EN
        // mask 1010_0101 serves 7,5,2,0 then wraps to 7
        cfg_num_pec  = 4'd8;
        cfg_pec_mask = 8'hA5;
        top_sta      = 1'b1;
        tick();
        top_sta = 1'b0;
        check("m_cur_start", 32'(cur_pec), 32'd7);
        wait_state(2'd2, "m_waitget");
        dis_rdy_wei = 1'b1;
        exp_q.push_back(8'h80);
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h04);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h80);
        serve(5, "m");
        dis_rdy_wei = 1'b0;
        fnh_cfg     = 1'b1;
        tick();
        fnh_cfg      = 1'b0;
        cfg_pec_mask = 8'h00;
        top_sta      = 1'b1;
        tick();
        top_sta = 1'b0;
        check("m_zero_mask_idle", 32'(busy), 32'd0);
        tick();
        check("m_zero_mask_stay", 32'(busy), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ctrl_wei_sched.md
CTRL_WEI_SCHED -- requirements
Module: ctrl_wei_sched

Interface
REQ-001 Parameter NUM_PEC, default 48, number of PEC weight ports.
REQ-002 Parameter PREFETCH_DEPTH, default 3, fetch pulses issued ahead on start/new frame (range 1..15).
REQ-003 Constant IDW = clog2(NUM_PEC), PEC index width.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 top_sta  in  1  start pulse.
REQ-007 gbf_flg_val, gbf_wei_val  in  1 each  weight-flag / weight buffer valid.
REQ-008 cfg_num_pec  in  IDW+1  active PEC count, sampled on start.
REQ-009 cfg_pec_mask  in  NUM_PEC  per-PEC enable (present only with CTRL_WEI_MASK_EN).
REQ-010 dis_rdy_wei  in  1  distributor holds a weight set.
REQ-011 pec_get_wei  in  NUM_PEC  PEC takes weights.
REQ-012 fnh_frm  in  1  frame finished; fnh_cfg  in  1  layer config finished.
REQ-013 pec_rdy_wei  out  NUM_PEC  weights-ready, registered, at most one bit set.
REQ-014 pls_fetch  out  1  combinational one-cycle fetch pulse to buffer.
REQ-015 cur_pec  out  IDW  PEC currently served; busy  out  1  state != IDLE; err_get  out  1  sticky.

Function
REQ-016 wei_val = gbf_flg_val AND gbf_wei_val.
REQ-017 States IDLE, PREFETCH, WAITGET, WAITVAL; 2-bit counter-free encoding, pf_cnt 4-bit.
REQ-018 IDLE: top_sta -> PREFETCH, pf_cnt=0, latch n_act = cfg_num_pec (0 or >NUM_PEC clamps to NUM_PEC), cur_pec = n_act-1.
REQ-019 PREFETCH: wei_val and pf_cnt<PREFETCH_DEPTH -> pls_fetch=1, pf_cnt+1; wei_val and pf_cnt==PREFETCH_DEPTH -> WAITGET, no pulse; no wei_val -> hold.
REQ-020 WAITGET priority: fnh_cfg -> IDLE; else fnh_frm -> PREFETCH, pf_cnt=0, cur_pec=n_act-1; else any pec_get_wei bit -> WAITVAL.
REQ-021 WAITVAL: wei_val -> WAITGET, pls_fetch=1 same cycle, cur_pec decrements; at 0 wraps to n_act-1; no wei_val -> hold, no pulse.
REQ-022 pec_rdy_wei: cleared when any pec_get_wei bit or fnh_frm; else bit cur_pec set when dis_rdy_wei and state==WAITGET; clear wins over set.
REQ-023 pec_get_wei bit other than cur_pec, or in a state other than WAITGET, sets err_get until reset; state behaviour unchanged.
REQ-024 Exactly PREFETCH_DEPTH pulses per start/frame, then one pulse per served PEC; latency get->pulse 1 cycle minimum.
REQ-025 top_sta outside IDLE ignored; fnh_frm/fnh_cfg outside WAITGET ignored.

Reset
REQ-026 rst high at any edge, mid-operation included: state=IDLE, pf_cnt=0, cur_pec=NUM_PEC-1, n_act=NUM_PEC, pec_rdy_wei=0, err_get=0; pls_fetch=0 while rst high.

Configuration
REQ-027 CTRL_WEI_MASK_EN defined: cfg_pec_mask port present, sampled with cfg_num_pec; cur_pec start/decrement/wrap select the next lower enabled index below n_act, skipping disabled PECs; all-zero mask -> top_sta ignored, stay IDLE.
REQ-028 CTRL_WEI_MASK_EN undefined: no mask port, all PECs below n_act served.

Structure
REQ-029 Shared package ctrl_wei_pkg: state encoding, clog2 function, default NUM_PEC/PREFETCH_DEPTH.
REQ-030 Sub-module ctrl_wei_pick: combinational next-enabled-index finder (decrement with wrap, mask-aware); single instance.

Verification
REQ-031 Reset, top_sta, wei_val=1 steady -> exactly 3 pls_fetch in consecutive cycles, WAITGET on cycle 5.
REQ-032 cfg_num_pec=4, dis_rdy_wei=1, PEC replies get each ready -> rdy order bits 3,2,1,0,3; one pls_fetch per get after wei_val.
REQ-033 fnh_frm in WAITGET with rdy bit 2 set -> pec_rdy_wei=0 next cycle, 3 new prefetch pulses, cur_pec=n_act-1.
REQ-034 get on bit 5 while cur_pec=7 -> err_get=1 and held; also dis_rdy_wei and get same cycle -> rdy stays 0.
REQ-035 CTRL_WEI_MASK_EN, NUM_PEC=8, mask=8'b1010_0101 -> service order 7,5,2,0,7; mask=0 -> busy stays 0.
REQ-036 rst asserted in WAITVAL with wei_val=1 -> no pls_fetch, IDLE and all reset values next cycle.
